// File: rtl/hamming_pkg.sv
// hamming_pkg: shared states, SECDED bit positions and default job addresses
package hamming_pkg;
   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_e;
   localparam int P16_POS = 0;
   localparam int P1_POS  = 1;
   localparam int P2_POS  = 2;
   localparam int P4_POS  = 4;
   localparam int P8_POS  = 8;
   localparam logic [7:0]  ENC_SRC_DEF  = 8'd0;
   localparam logic [7:0]  ENC_DST_DEF  = 8'd30;
   localparam logic [7:0]  DEC_SRC_DEF  = 8'd64;
   localparam logic [7:0]  DEC_DST_DEF  = 8'd94;
   localparam logic [15:0] DBL_ERR_WORD = 16'h8000;
endpackage

// File: rtl/hamming_codec.sv
// hamming_codec: combinational SECDED(16,11) encoder and single-correct/double-detect decoder
module hamming_codec
   import hamming_pkg::*;
(
   input  logic        mode,
   input  logic [7:0]  lo,
   input  logic [7:0]  hi,
   output logic [15:0] result,
   output logic        single_err,
   output logic        double_err
);
   logic [11:1] d;
   logic [15:0] enc, word, corr;
   logic [3:0]  syn;
   logic        q;
   always_comb begin
      d = {hi[2:0], lo};
      enc = {d[11:5], 1'b0, d[4:2], 1'b0, d[1], 3'b000};
      enc[P8_POS] = ^d[11:5];
      enc[P4_POS] = (^d[11:8]) ^ (^d[4:2]);
      enc[P2_POS] = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      enc[P1_POS] = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      enc[P16_POS] = ^enc[15:1];
      word = {hi, lo};
      syn = '0;
      for (int k = 1; k < 16; k++) syn = syn ^ (word[k] ? 4'(k) : 4'd0);
      q = ^word;
      // a zero syndrome with odd parity points at the overall parity bit 0
      corr = word ^ (q ? (16'd1 << syn) : 16'd0);
      single_err = q;
      double_err = !q && syn != 4'd0;
      result = !mode ? enc : double_err ? DBL_ERR_WORD : {5'b0, corr[15:9], corr[7:5], corr[3]};
   end
endmodule

// File: rtl/hamming_seq.sv
// hamming_seq: memory-to-memory SECDED encode/decode job sequencer
module hamming_seq
   import hamming_pkg::*;
#(
   parameter int         NUM_MSG = 15,
   parameter logic [7:0] ENC_SRC = ENC_SRC_DEF,
   parameter logic [7:0] ENC_DST = ENC_DST_DEF,
   parameter logic [7:0] DEC_SRC = DEC_SRC_DEF,
   parameter logic [7:0] DEC_DST = DEC_DST_DEF
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       start,
   input  logic       mode,
   output logic       halt,
   output logic [7:0] mem_addr,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_data,
   input  logic [7:0] mem_rd_data,
   output logic [3:0] err1_cnt,
   output logic [3:0] err2_cnt
);
   state_e      state_q, state_d;
   logic [7:0]  idx_q, idx_d, lo_q, lo_d, hi_q, hi_d, off, rd_base, wr_base;
   logic        mode_q, mode_d, start_q, halt_q, halt_d, single_err, double_err, last;
   logic [3:0]  err1_q, err1_d, err2_q, err2_d;
   logic [15:0] result;

   hamming_codec u_codec (
      .mode(mode_q), .lo(lo_q), .hi(hi_q), .result(result),
      .single_err(single_err), .double_err(double_err)
   );

   assign off      = idx_q << 1;
   assign rd_base  = (mode_q ? DEC_SRC : ENC_SRC) + off;
   assign wr_base  = (mode_q ? DEC_DST : ENC_DST) + off;
   assign last     = idx_q == 8'(NUM_MSG - 1);
   assign halt     = halt_q;
   assign err1_cnt = err1_q;
   assign err2_cnt = err2_q;

   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      mode_d = mode_q;
      lo_d = lo_q;
      hi_d = hi_q;
      err1_d = err1_q;
      err2_d = err2_q;
      halt_d = 1'b0;
      mem_addr = 8'd0;
      mem_wr_en = 1'b0;
      mem_wr_data = 8'd0;
      case (state_q)
         IDLE: if (start_q && !start) begin
            state_d = RD_LO;
            mode_d = mode;
            idx_d = 8'd0;
            err1_d = mode ? 4'd0 : err1_q;
            err2_d = mode ? 4'd0 : err2_q;
         end
         RD_LO: begin
            mem_addr = rd_base;
            lo_d = mem_rd_data;
            state_d = RD_HI;
         end
         RD_HI: begin
            mem_addr = rd_base + 8'd1;
            hi_d = mem_rd_data;
            state_d = WR_LO;
         end
         WR_LO: begin
            mem_addr = wr_base;
            mem_wr_en = 1'b1;
            mem_wr_data = result[7:0];
            err1_d = (mode_q && single_err && err1_q != 4'hF) ? err1_q + 4'd1 : err1_q;
            err2_d = (mode_q && double_err && err2_q != 4'hF) ? err2_q + 4'd1 : err2_q;
            state_d = WR_HI;
         end
         WR_HI: begin
            mem_addr = wr_base + 8'd1;
            mem_wr_en = 1'b1;
            mem_wr_data = result[15:8];
            idx_d = last ? idx_q : idx_q + 8'd1;
            state_d = last ? DONE : RD_LO;
         end
         DONE: begin
            // halt is registered, so it rises one edge after DONE is entered
            halt_d = !(halt_q && start);
            state_d = (halt_q && start) ? IDLE : DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         idx_q <= 8'd0;
         mode_q <= 1'b0;
         lo_q <= 8'd0;
         hi_q <= 8'd0;
         start_q <= 1'b1;
         halt_q <= 1'b0;
         err1_q <= 4'd0;
         err2_q <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         mode_q <= mode_d;
         lo_q <= lo_d;
         hi_q <= hi_d;
         start_q <= start;
         halt_q <= halt_d;
         err1_q <= err1_d;
         err2_q <= err2_d;
      end
   end
endmodule

// File: tb/tb_hamming_seq.sv
// tb_hamming_seq: scoreboard bench for hamming_seq encode/decode jobs, abort and start handling
module tb_hamming_seq;
   logic       CLK = 1'b0;
   logic       Reset = 1'b0;
   logic       start = 1'b1;
   logic       mode = 1'b0;
   logic       halt, mem_wr_en;
   logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
   logic [3:0] err1_cnt, err2_cnt;

   hamming_seq dut (
      .CLK(CLK), .Reset(Reset), .start(start), .mode(mode), .halt(halt),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data), .err1_cnt(err1_cnt), .err2_cnt(err2_cnt)
   );

   always #5 CLK = ~CLK;

   logic [7:0] mem [256];
   assign mem_rd_data = mem[mem_addr];
   always @(posedge CLK) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
      logic [3:0] e1;
      logic [3:0] e2;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int n_vec = 0;
   int n_fail = 0;
   logic [3:0] exp_e1 = 4'd0;
   logic [3:0] exp_e2 = 4'd0;

   // {hi,lo} source words and hand-encoded codewords
   logic [15:0] enc_in  [7] = '{16'h0000, 16'h07FF, 16'h0001, 16'h0400, 16'h0080, 16'h0002, 16'h0010};
   logic [15:0] enc_out [7] = '{16'h0000, 16'hFFFF, 16'h000F, 16'h8117, 16'h1111, 16'h0033, 16'h0303};
   // received words, hand-decoded results, kind 0=clean 1=single 2=double
   logic [15:0] dec_in  [10] = '{16'h020F, 16'h000E, 16'h030F, 16'h000F, 16'hFFFF,
                                 16'h0117, 16'h0000, 16'h0001, 16'h0003, 16'h8117};
   logic [15:0] dec_out [10] = '{16'h0001, 16'h0001, 16'h8000, 16'h0001, 16'h07FF,
                                 16'h0400, 16'h0000, 16'h0000, 16'h8000, 16'h0400};
   int          dec_kind[10] = '{1, 1, 2, 0, 0, 1, 0, 1, 2, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) if (mem_wr_en) begin
      if (sb.size() == 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wr_data);
      end else begin
         mon_e = sb.pop_front();
         chk("wr_addr", 32'(mem_addr), 32'(mon_e.a));
         chk("wr_data", 32'(mem_wr_data), 32'(mon_e.d));
         chk("err1_cnt", 32'(err1_cnt), 32'(mon_e.e1));
         chk("err2_cnt", 32'(err2_cnt), 32'(mon_e.e2));
      end
   end

   task automatic load_job(input bit m);
      logic [15:0] w, r;
      int kind;
      if (m) begin
         exp_e1 = 4'd0;
         exp_e2 = 4'd0;
      end
      for (int i = 0; i < 15; i++) begin
         w = m ? dec_in[i % 10] : enc_in[i % 7];
         r = m ? dec_out[i % 10] : enc_out[i % 7];
         kind = m ? dec_kind[i % 10] : 0;
         mem[(m ? 64 : 0) + 2 * i] = w[7:0];
         mem[(m ? 64 : 0) + 2 * i + 1] = w[15:8];
         mem[(m ? 94 : 30) + 2 * i] = 8'hA5;
         mem[(m ? 94 : 30) + 2 * i + 1] = 8'hA5;
         sb.push_back('{8'((m ? 94 : 30) + 2 * i), r[7:0], exp_e1, exp_e2});
         if (kind == 1 && exp_e1 != 4'hF) exp_e1 = exp_e1 + 4'd1;
         if (kind == 2 && exp_e2 != 4'hF) exp_e2 = exp_e2 + 4'd1;
         sb.push_back('{8'((m ? 94 : 30) + 2 * i + 1), r[15:8], exp_e1, exp_e2});
      end
   endtask

   task automatic run_job(input bit m, input bit toggle, input int abort_at);
      int k;
      load_job(m);
      @(posedge CLK);
      #1 mode = m;
      start = 1'b0;
      @(posedge CLK);
      #1 mode = ~m;
      k = 0;
      while (k < 100) begin
         @(posedge CLK);
         #1 k++;
         if (toggle && k == 10) start = 1'b1;
         if (toggle && k == 12) start = 1'b0;
         if (k == abort_at || halt) break;
      end
      if (abort_at != 0) begin
         Reset = 1'b0;
         start = 1'b1;
         #1;
         chk("abort_halt", 32'(halt), 32'd0);
         chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
         chk("abort_addr", 32'(mem_addr), 32'd0);
         chk("abort_wr_data", 32'(mem_wr_data), 32'd0);
         sb.delete();
         exp_e1 = 4'd0;
         exp_e2 = 4'd0;
         repeat (3) @(posedge CLK);
         #1 Reset = 1'b1;
         repeat (70) @(posedge CLK);
         #1 chk("abort_no_relaunch_halt", 32'(halt), 32'd0);
         return;
      end
      chk("halt_edge", 32'(k), 32'd61);
      @(posedge CLK);
      #1 chk("halt_hold", 32'(halt), 32'd1);
      start = 1'b1;
      @(posedge CLK);
      #1 chk("halt_clear", 32'(halt), 32'd0);
      chk("writes_outstanding", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
      chk("rst_err1", 32'(err1_cnt), 32'd0);
      chk("rst_err2", 32'(err2_cnt), 32'd0);
      Reset = 1'b1;
      run_job(1'b0, 1'b1, 0);
      for (int i = 0; i < 30; i++)
         chk("src_untouched", 32'(mem[i]), 32'(i % 2 ? enc_in[(i / 2) % 7][15:8] : enc_in[(i / 2) % 7][7:0]));
      run_job(1'b1, 1'b0, 0);
      chk("final_err1", 32'(err1_cnt), 32'd6);
      chk("final_err2", 32'(err2_cnt), 32'd3);
      run_job(1'b0, 1'b0, 20);
      run_job(1'b0, 1'b0, 0);
      chk("relaunch_byte", 32'(mem[32'd30 + 32'd3]), 32'hFF);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
